icache_fetch: RTL

ICACHE_FETCH -- requirements
Module: icache_fetch

---
 rtl/icache_fetch_if.sv | 41 ++++
 rtl/icache_fetch.sv | 125 ++++++++++++
 2 files changed

// File: rtl/icache_fetch_if.sv
// icache_fetch_if -- fetch-side bundle between the core front end, the
// direct-mapped instruction cache and the memory controller.
//   slave  : the cache (drives stall/mem request/instruction outputs)
//   master : the core/memory side (drives PC, redirect, flush, mem response)
// Optional ICACHE_PERF_EN adds hit_cnt_o / miss_cnt_o.
interface icache_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc_i;
  logic                  pc_valid_i;
  logic                  jump_i;
  logic                  flush_i;
  logic                  stall_req_o;
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_ready_i;
  logic [31:0]           mem_data_i;
  logic                  inst_valid_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic [31:0]           inst_o;
`ifdef ICACHE_PERF_EN
  logic [31:0]           hit_cnt_o;
  logic [31:0]           miss_cnt_o;
`endif

  modport slave (
    input  pc_i, pc_valid_i, jump_i, flush_i, mem_ready_i, mem_data_i,
    output stall_req_o, mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o
`ifdef ICACHE_PERF_EN
    , output hit_cnt_o, miss_cnt_o
`endif
  );

  modport master (
    output pc_i, pc_valid_i, jump_i, flush_i, mem_ready_i, mem_data_i,
    input  stall_req_o, mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o
`ifdef ICACHE_PERF_EN
    , input hit_cnt_o, miss_cnt_o
`endif
  );
endinterface

// File: rtl/icache_fetch.sv
// icache_fetch -- direct-mapped, one-word-per-line instruction cache in the
// fetch stage. Hits return the instruction in the same cycle; a miss stalls
// the front end, issues a single-word read and bypasses the returned word
// straight to IF/ID while writing the line.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : icache_fetch_if.slave (PC request, redirect/flush, stall,
//          memory request/response, instruction output)
// Optional feature macro ICACHE_PERF_EN: 32-bit hit/miss counters
// (hit_cnt_o / miss_cnt_o on the interface); they are not cleared by flush.
module icache_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
  input logic           clk,
  input logic           rst,
  icache_fetch_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MISS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_miss_pc;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [31:0]           r_data [LINES];

  logic [INDEX_BITS-1:0] w_idx, w_midx;
  logic [TAG_BITS-1:0]   w_tag, w_mtag;
  logic                  w_hit, w_req, w_hit_out, w_miss_start;
  logic                  w_fill, w_fill_out, w_write;

  assign w_idx  = bus.pc_i[INDEX_BITS+1:2];
  assign w_tag  = bus.pc_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_midx = r_miss_pc[INDEX_BITS+1:2];
  assign w_mtag = r_miss_pc[ADDR_WIDTH-1:INDEX_BITS+2];

  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // rst gates the combinational request path so every output is 0 while
  // reset is held, even if the core keeps pc_valid_i high.
  assign w_req        = rst && (r_state == S_IDLE) && bus.pc_valid_i &&
                        !bus.jump_i && !bus.flush_i;
  assign w_hit_out    = w_req && w_hit;
  assign w_miss_start = w_req && !w_hit;

  // Fill completes in MISS; a redirect still keeps the line (it is good
  // data), but a flush in the same cycle must leave the line invalid.
  assign w_fill     = rst && (r_state == S_MISS) && bus.mem_ready_i;
  assign w_write    = w_fill && !bus.flush_i;
  assign w_fill_out = w_fill && !bus.jump_i && !bus.flush_i;

  assign bus.inst_valid_o = w_hit_out || w_fill_out;
  assign bus.pc_o   = w_hit_out  ? bus.pc_i  :
                      w_fill_out ? r_miss_pc : '0;
  assign bus.inst_o = w_hit_out  ? r_data[w_idx] :
                      w_fill_out ? bus.mem_data_i : '0;

  // Stall drops in the completing MISS cycle so the PC advances together
  // with the bypassed instruction; DROP holds until its response arrives.
  assign bus.stall_req_o = w_miss_start ||
                           ((r_state == S_MISS) && !bus.mem_ready_i) ||
                           (r_state == S_DROP);
  assign bus.mem_req_o   = (r_state != S_IDLE);
  assign bus.mem_addr_o  = (r_state != S_IDLE) ? r_miss_pc : '0;

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  assign bus.hit_cnt_o  = r_hit_cnt;
  assign bus.miss_cnt_o = r_miss_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_miss_pc <= '0;
      r_valid   <= '0;
`ifdef ICACHE_PERF_EN
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss_start) begin
            r_miss_pc <= bus.pc_i;
            r_state   <= S_MISS;
          end
        end
        S_MISS: begin
          if (bus.mem_ready_i)                  r_state <= S_IDLE;
          else if (bus.jump_i || bus.flush_i)   r_state <= S_DROP;
        end
        S_DROP: begin
          if (bus.mem_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_write)     r_valid[w_midx] <= 1'b1;
      // Later assignment wins: flush beats a coincident fill.
      if (bus.flush_i) r_valid <= '0;

`ifdef ICACHE_PERF_EN
      if (w_hit_out)    r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_start) r_miss_cnt <= r_miss_cnt + 32'd1;
`endif
    end
  end

  // Tag/data arrays need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_tag[w_midx]  <= w_mtag;
      r_data[w_midx] <= bus.mem_data_i;
    end
  end
endmodule
